// File: rtl/lcd_pkg.sv
// lcd_pkg: command encodings, geometry, default fill and FSM state type shared with the LCD driver top.
package lcd_pkg;
  localparam logic [1:0] CMD_PUT = 2'b00;
  localparam logic [1:0] CMD_SET = 2'b01;
  localparam logic [1:0] CMD_CLR = 2'b10;
  localparam logic [1:0] CMD_NL  = 2'b11;
  localparam int LINE_CHARS = 16;
  localparam int NUM_CELLS  = 32;
  localparam logic [7:0] FILL_DEFAULT = 8'h20;
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;
endpackage

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: one-cycle tick every SCROLL_DIV clocks; only built when LCD_SCROLL_EN is defined.
`ifdef LCD_SCROLL_EN
module lcd_tick_gen #(
  parameter int SCROLL_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == 32'(SCROLL_DIV - 1)) ? '0 : cnt + 32'd1;
      tick <= (cnt == 32'(SCROLL_DIV - 1));
    end
endmodule
`endif

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 2x16 character buffer with put/set-cursor/clear/newline commands.
// Optional LCD_SCROLL_EN rotates line1 left by a periodically advancing offset.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR  = FILL_DEFAULT,
  parameter int         SCROLL_DIV = 12_500_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [1:0]   wr_cmd,
  input  logic [7:0]   wr_data,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         update,
  output logic [4:0]   cursor
);
  logic [0:NUM_CELLS-1][7:0] cells;
  state_t     state;
  logic [4:0] clr_idx;
  logic       accept;
  logic       tick;
  assign wr_ready = (state == ST_IDLE);
  assign accept   = wr_valid && wr_ready;
  assign line2    = cells[LINE_CHARS:NUM_CELLS-1];
`ifdef LCD_SCROLL_EN
  logic [3:0]   offset;
  logic [255:0] dbl;
  lcd_tick_gen #(.SCROLL_DIV(SCROLL_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) offset <= '0;
    else offset <= (accept && wr_cmd == CMD_CLR) ? 4'd0 : tick ? offset + 4'd1 : offset;
  // Column c shows cell (c + offset) mod 16.
  assign dbl   = {cells[0:LINE_CHARS-1], cells[0:LINE_CHARS-1]} << {offset, 3'b000};
  assign line1 = dbl[255:128];
`else
  assign tick  = 1'b0;
  assign line1 = cells[0:LINE_CHARS-1];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cells   <= {NUM_CELLS{FILL_CHAR}};
      state   <= ST_IDLE;
      clr_idx <= '0;
      cursor  <= '0;
      update  <= 1'b0;
    end else if (state == ST_CLEAR) begin
      cells[clr_idx] <= FILL_CHAR;
      clr_idx        <= clr_idx + 5'd1;
      update         <= tick || (clr_idx == 5'd31);
      if (clr_idx == 5'd31) begin
        state  <= ST_IDLE;
        cursor <= '0;
      end
    end else begin
      update <= tick || (accept && wr_cmd == CMD_PUT);
      if (accept)
        case (wr_cmd)
          CMD_PUT: begin
            cells[cursor] <= wr_data;
            cursor        <= cursor + 5'd1;
          end
          CMD_SET: cursor <= wr_data[4:0];
          CMD_CLR: begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
          end
          default: cursor <= cursor[4] ? 5'd0 : 5'd16;
        endcase
    end
endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed self-checking bench for lcd_text_buffer (default build).
module tb_lcd_text_buffer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [1:0]   wr_cmd = 2'b00;
  logic [7:0]   wr_data = 8'h00;
  logic [127:0] line1, line2;
  logic         update;
  logic [4:0]   cursor;
  int total = 0;
  int bad = 0;
  localparam logic [127:0] FILL = {16{8'h20}};

  lcd_text_buffer dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_cmd(wr_cmd), .wr_data(wr_data), .line1(line1), .line2(line2),
    .update(update), .cursor(cursor)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_cmd   = c;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (line1 !== FILL) begin bad++; $display("FAIL reset_line1 got=%h exp=%h", line1, FILL); end
    total++; if (line2 !== FILL) begin bad++; $display("FAIL reset_line2 got=%h exp=%h", line2, FILL); end
    total++; if (cursor !== 5'd0) begin bad++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update got=%b exp=0", update); end
  endtask

  task automatic test_back_to_back();
    wr_valid = 1'b1; wr_cmd = 2'b00; wr_data = 8'h48;
    step();
    total++; if (update !== 1'b1) begin bad++; $display("FAIL b2b_update1 got=%b exp=1", update); end
    wr_data = 8'h49;
    step();
    wr_valid = 1'b0;
    total++; if (update !== 1'b1) begin bad++; $display("FAIL b2b_update2 got=%b exp=1", update); end
    total++; if (line1[127:112] !== 16'h4849) begin bad++; $display("FAIL b2b_line1 got=%h exp=4849", line1[127:112]); end
    total++; if (cursor !== 5'd2) begin bad++; $display("FAIL b2b_cursor got=%0d exp=2", cursor); end
    step();
    total++; if (update !== 1'b0) begin bad++; $display("FAIL b2b_update_end got=%b exp=0", update); end
  endtask

  task automatic test_wrap();
    send(2'b01, 8'd31);
    total++; if (cursor !== 5'd31) begin bad++; $display("FAIL set_cursor got=%0d exp=31", cursor); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL set_no_update got=%b exp=0", update); end
    send(2'b00, 8'h41);
    total++; if (line2[7:0] !== 8'h41) begin bad++; $display("FAIL wrap_line2 got=%h exp=41", line2[7:0]); end
    total++; if (cursor !== 5'd0) begin bad++; $display("FAIL wrap_cursor got=%0d exp=0", cursor); end
    send(2'b11, 8'h00);
    total++; if (cursor !== 5'd16) begin bad++; $display("FAIL nl_cursor got=%0d exp=16", cursor); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL nl_no_update got=%b exp=0", update); end
    send(2'b11, 8'h00);
    total++; if (cursor !== 5'd0) begin bad++; $display("FAIL nl2_cursor got=%0d exp=0", cursor); end
    total++; if (line1[127:112] !== 16'h4849) begin bad++; $display("FAIL nl_cells got=%h exp=4849", line1[127:112]); end
  endtask

  task automatic test_clear();
    int lo = 0;
    int ups = 0;
    send(2'b01, 8'd20);
    send(2'b00, 8'h33);
    send(2'b00, 8'h5A);
    send(2'b10, 8'h00);
    wr_valid = 1'b1; wr_cmd = 2'b00; wr_data = 8'h5A;
    for (int i = 0; i < 40 && wr_ready !== 1'b1; i++) begin
      lo++;
      if (update === 1'b1) ups++;
      step();
    end
    total++; if (lo !== 32) begin bad++; $display("FAIL clear_busy_cycles got=%0d exp=32", lo); end
    total++; if (ups !== 0) begin bad++; $display("FAIL clear_early_update got=%0d exp=0", ups); end
    total++; if (update !== 1'b1) begin bad++; $display("FAIL clear_update got=%b exp=1", update); end
    total++; if (line1 !== FILL) begin bad++; $display("FAIL clear_line1 got=%h exp=%h", line1, FILL); end
    total++; if (line2 !== FILL) begin bad++; $display("FAIL clear_line2 got=%h exp=%h", line2, FILL); end
    total++; if (cursor !== 5'd0) begin bad++; $display("FAIL clear_cursor got=%0d exp=0", cursor); end
    step();
    wr_valid = 1'b0;
    total++; if (line1[127:120] !== 8'h5A) begin bad++; $display("FAIL held_cmd_cell0 got=%h exp=5a", line1[127:120]); end
    total++; if (cursor !== 5'd1) begin bad++; $display("FAIL held_cmd_cursor got=%0d exp=1", cursor); end
    step();
    total++; if (update !== 1'b0) begin bad++; $display("FAIL clear_single_pulse got=%b exp=0", update); end
  endtask

  task automatic test_reset_mid_clear();
    send(2'b01, 8'd30);
    send(2'b00, 8'h77);
    send(2'b10, 8'h00);
    for (int i = 0; i < 10; i++) step();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b exp=0", wr_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (line1 !== FILL) begin bad++; $display("FAIL midclr_line1 got=%h exp=%h", line1, FILL); end
    total++; if (line2 !== FILL) begin bad++; $display("FAIL midclr_line2 got=%h exp=%h", line2, FILL); end
    total++; if (cursor !== 5'd0) begin bad++; $display("FAIL midclr_cursor got=%0d exp=0", cursor); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL midclr_ready got=%b exp=1", wr_ready); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL midclr_update got=%b exp=0", update); end
    send(2'b00, 8'h42);
    total++; if (line1[127:120] !== 8'h42) begin bad++; $display("FAIL midclr_put got=%h exp=42", line1[127:120]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
